// File: rtl/multi_channel_clock_gate_ctrl_pkg.sv
// Shared definitions for the multi-channel clock-gate controller.
// Holds the per-channel FSM state encoding and the default parameter values
// used by the top module.
package multi_channel_clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ON        = 2'd1,
    ST_IDLE_WAIT = 2'd2
  } ch_state_e;

  localparam int NUM_CH_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int IDLE_CNT_W_DEF  = 8;

endpackage

// File: rtl/multi_channel_clock_gate_ctrl_clock_gate_cell.sv
// Integrated clock-gating cell: a latch that is transparent while clk_in is
// low, followed by an AND with clk_in. Because the enable can only change
// while clk_in is low, the gated output never produces a truncated pulse.
// Ports:
//   clk_in  - root clock
//   en      - clock enable, may change at any time
//   clk_out - gated clock
module clock_gate_cell (
  input  logic clk_in,
  input  logic en,
  output logic clk_out
);

  logic latch_q;

  always_latch begin
    if (!clk_in) latch_q <= en;
  end

  assign clk_out = clk_in & latch_q;

endmodule

// File: rtl/multi_channel_clock_gate_ctrl.sv
// Multi-channel clock-gating controller.
// Each channel synchronises its asynchronous enable request, runs a small
// OFF / ON / IDLE_WAIT FSM with an idle hysteresis counter, and drives a
// latch-based ICG cell. test_mode forces every gated clock to run without
// disturbing the FSMs.
// Ports:
//   clk_in      - root clock (ungated)
//   rst_n       - synchronous active-low reset
//   en_req      - per-channel enable request, asynchronous to clk_in
//   busy        - per-channel activity flag, synchronous; holds clock on
//   idle_thresh - idle cycles required before gating (quasi-static)
//   test_mode   - forces all clk_out to follow clk_in
//   clk_out     - gated clocks
//   ch_active   - 1 while the channel FSM is not OFF
//   all_idle    - 1 when every channel FSM is OFF
module multi_channel_clock_gate_ctrl
  import multi_channel_clock_gate_ctrl_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int IDLE_CNT_W  = IDLE_CNT_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     en_req,
  input  logic [NUM_CH-1:0]     busy,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  test_mode,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     ch_active,
  output logic                  all_idle
);

  // Synchroniser: row 0 captures en_req, the last row is the synchronised value.
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  en_sync;
  logic [NUM_CH-1:0]                  clk_en;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], en_req};
    end
  end

  assign en_sync = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Per-channel FSM state is kept here so it can be probed hierarchically.
    ch_state_e             state_q;
    logic [IDLE_CNT_W-1:0] cnt_q;
    logic [IDLE_CNT_W-1:0] thr_q;

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        thr_q   <= '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            // busy alone never wakes a gated channel
            if (en_sync[i]) state_q <= ST_ON;
          end
          ST_ON: begin
            if (!en_sync[i] && !busy[i]) begin
              if (idle_thresh != '0) begin
                state_q <= ST_IDLE_WAIT;
                cnt_q   <= IDLE_CNT_W'(1);
                thr_q   <= idle_thresh;
              end else begin
                state_q <= ST_OFF;
              end
            end
          end
          ST_IDLE_WAIT: begin
            // Wake takes priority over expiry in the same cycle.
            if (en_sync[i] || busy[i]) begin
              state_q <= ST_ON;
              cnt_q   <= '0;
            end else if (cnt_q == thr_q) begin
              state_q <= ST_OFF;
              cnt_q   <= '0;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign ch_active[i] = (state_q != ST_OFF);
    assign clk_en[i]    = ch_active[i] | test_mode;

    clock_gate_cell u_icg (
      .clk_in  (clk_in),
      .en      (clk_en[i]),
      .clk_out (clk_out[i])
    );
  end

  assign all_idle = ~|ch_active;

endmodule

// File: tb/tb_multi_channel_clock_gate_ctrl.sv
// Bench for multi_channel_clock_gate_ctrl. A reference model, written as
// "channel is active until it has seen thr+1 consecutive idle edges", pushes
// the expected outputs for each rising edge into exp_q; a monitor pops and
// compares them shortly after the edge.
module tb_multi_channel_clock_gate_ctrl;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int IDLE_CNT_W  = 8;
  localparam int EW          = 2 * NUM_CH + 2;

  logic                  clk_in;
  logic                  rst_n;
  logic [NUM_CH-1:0]     en_req;
  logic [NUM_CH-1:0]     busy;
  logic [IDLE_CNT_W-1:0] idle_thresh;
  logic                  test_mode;
  logic [NUM_CH-1:0]     clk_out;
  logic [NUM_CH-1:0]     ch_active;
  logic                  all_idle;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  multi_channel_clock_gate_ctrl #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_CNT_W  (IDLE_CNT_W)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en_req      (en_req),
    .busy        (busy),
    .idle_thresh (idle_thresh),
    .test_mode   (test_mode),
    .clk_out     (clk_out),
    .ch_active   (ch_active),
    .all_idle    (all_idle)
  );

  // ---------------- clock ----------------
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- reference model ----------------
  logic [NUM_CH-1:0] m_active;
  logic [NUM_CH-1:0] m_hist [SYNC_STAGES];
  int                m_run  [NUM_CH];
  int                m_thr  [NUM_CH];
  bit                m_known = 1'b0;

  always @(posedge clk_in) begin
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] sync_v;
    bit                chk;
    // clk_out in this high phase reflects what the latch saw in the low phase
    exp_clk = m_active | {NUM_CH{test_mode}};
    chk     = m_known;
    if (!rst_n) begin
      m_active = '0;
      for (int s = 0; s < SYNC_STAGES; s++) m_hist[s] = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 0;
        m_thr[i] = 0;
      end
    end else begin
      sync_v = m_hist[SYNC_STAGES-1];
      for (int i = 0; i < NUM_CH; i++) begin
        if (!m_active[i]) begin
          m_active[i] = sync_v[i];
          m_run[i]    = 0;
        end else if (sync_v[i] || busy[i]) begin
          m_run[i] = 0;
        end else begin
          if (m_run[i] == 0) m_thr[i] = int'(idle_thresh);
          m_run[i]++;
          if (m_run[i] > m_thr[i]) begin
            m_active[i] = 1'b0;
            m_run[i]    = 0;
          end
        end
      end
      for (int s = SYNC_STAGES - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = en_req;
    end
    m_known = 1'b1;
    exp_q.push_back({chk, exp_clk, ~|m_active, m_active});
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t got=empty required=entry", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (ch_active !== e[NUM_CH-1:0]) begin
          failures++;
          $display("FAIL ch_active t=%0t got=%b required=%b", $time, ch_active, e[NUM_CH-1:0]);
        end
        checks++;
        if (all_idle !== e[NUM_CH]) begin
          failures++;
          $display("FAIL all_idle t=%0t got=%b required=%b", $time, all_idle, e[NUM_CH]);
        end
        if (e[EW-1]) begin
          checks++;
          if (clk_out !== e[2*NUM_CH:NUM_CH+1]) begin
            failures++;
            $display("FAIL clk_out_high t=%0t got=%b required=%b", $time, clk_out, e[2*NUM_CH:NUM_CH+1]);
          end
        end
      end
      @(negedge clk_in);
      #1;
      if (m_known) begin
        checks++;
        if (clk_out !== '0) begin
          failures++;
          $display("FAIL clk_out_low t=%0t got=%b required=%b", $time, clk_out, {NUM_CH{1'b0}});
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    rst_n       = 1'b0;
    en_req      = 4'hF;
    busy        = '0;
    idle_thresh = 8'd4;
    test_mode   = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(6);

    // everyone idles down with threshold 4
    en_req = '0;
    step(12);

    // wake latency on channel 0 only
    en_req[0] = 1'b1;
    step(8);

    // hysteresis on channel 1
    en_req = 4'b0111;
    step(6);
    en_req[1] = 1'b0;
    step(10);

    // busy extension on channel 2 inside IDLE_WAIT
    en_req[2] = 1'b0;
    step(4);
    busy[2] = 1'b1;
    step(1);
    busy[2] = 1'b0;
    step(12);

    // zero threshold: direct ON -> OFF
    en_req      = 4'b1000;
    idle_thresh = 8'd0;
    step(4);
    en_req = '0;
    step(6);

    // threshold 2 with busy on the expiry cycle
    idle_thresh = 8'd2;
    en_req[3]   = 1'b1;
    step(4);
    en_req = '0;
    step(4);
    busy[3] = 1'b1;
    step(1);
    busy[3] = 1'b0;
    step(8);

    // busy while OFF must not wake anything
    busy = 4'hF;
    step(4);
    busy = '0;
    step(2);

    // test_mode with all channels off
    test_mode = 1'b1;
    step(4);
    test_mode = 1'b0;
    step(4);

    // randomised phase
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) en_req = NUM_CH'($urandom);
      busy = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      if ($urandom_range(0, 60) == 0) idle_thresh = IDLE_CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) test_mode = ~test_mode;
      rst_n = ($urandom_range(0, 150) != 0);
      step(1);
    end
    rst_n     = 1'b1;
    test_mode = 1'b0;
    en_req    = '0;
    busy      = '0;
    step(20);

    checks++;
    if (exp_q.size() > 1) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required<=1", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
